adc_axis_packer: RTL and testbench

- Upstream neighbour of the DDC receive path.
- Takes free-running I/Q sample strobes from the ADC capture side (no backpressure) and buffers them in a small FIFO.
- Emits fixed-length AXI-Stream packets with tlast, and feeds axis_0_rx/axis_1_rx of the conversion top.
- Handles start/stop framing, zero-pads partial packets on stop, and counts dropped samples and emitted packets.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/adc_axis_packer_fifo.sv | 50 +++++
 rtl/adc_axis_packer.sv | 163 ++++++++++++++++
 tb/tb_adc_axis_packer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the ADC-to-AXIS packer: FSM encoding, default
// packet length and the {Q, I} sample word layout.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [13:0] DEF_PKT_LEN = 14'd256;

  localparam int I_LSB = 0;
  localparam int Q_LSB = 16;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/adc_axis_packer_fifo.sv
// Single-clock FIFO with extra-MSB pointers; read data is presented
// combinationally from the head entry (show-ahead).
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A write into a full FIFO is still legal when the head is popped this cycle.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  assign wr_ptr_d  = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d  = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/adc_axis_packer.sv
// Packs free-running ADC I/Q strobes into fixed-length AXI-Stream packets,
// zero-padding the open packet when capture stops.
module adc_axis_packer
  import conv_pkg::*;
#(
  parameter int          U_DLY       = 1,
  parameter int          FIFO_AW     = 4,
  parameter logic [13:0] DEF_PKT_LEN = conv_pkg::DEF_PKT_LEN
) (
  input  logic        axis_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [13:0] pkt_len,
  input  logic        sample_valid,
  input  logic [31:0] sample_data,
  output logic        axis_tvalid,
  output logic [31:0] axis_tdata,
  output logic        axis_tlast,
  input  logic        axis_tready,
  input  logic        cnt_clr,
  output logic        busy,
  output logic        drop_flag,
  output logic [15:0] drop_cnt,
  output logic [15:0] pkt_cnt
);

  // Register timing is zero-delay here; the parameter is kept for interface parity.
  logic unused_udly;
  assign unused_udly = (U_DLY != 0);

  state_e      state_q, state_d;
  logic [13:0] len_q, len_d, pos_q, pos_d;
  logic        drop_flag_q, drop_flag_d;
  logic [15:0] drop_cnt_q, drop_cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic        out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [31:0] out_data_q, out_data_d;

  logic        fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [32:0] fifo_wdata, fifo_rdata;
  logic        pos_last, hs;
  logic [13:0] pos_next;

  sync_fifo #(.WIDTH(33), .AW(FIFO_AW)) u_fifo (
    .clk_i    (axis_clk),
    .rst_ni   (rst_n),
    .wr_en_i  (fifo_wr),
    .wr_data_i(fifo_wdata),
    .rd_en_i  (fifo_rd),
    .rd_data_o(fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign pos_last = (pos_q == len_q - 14'd1);
  assign pos_next = pos_last ? 14'd0 : pos_q + 14'd1;
  assign hs       = out_vld_q && axis_tready;
  // Output register refills on the handshake cycle, so full-rate streams have no bubbles.
  assign fifo_rd  = !fifo_empty && (!out_vld_q || axis_tready);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    pos_d       = pos_q;
    drop_flag_d = drop_flag_q;
    drop_cnt_d  = drop_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    fifo_wr     = 1'b0;
    fifo_wdata  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          len_d   = (pkt_len == 14'd0) ? DEF_PKT_LEN : pkt_len;
          pos_d   = '0;
        end
      end
      ST_RUN: begin
        if (sample_valid) begin
          if (!fifo_full) begin
            fifo_wr    = 1'b1;
            fifo_wdata = {pos_last, sample_data[Q_LSB +: 16], sample_data[I_LSB +: 16]};
            pos_d      = pos_next;
          end else begin
            drop_flag_d = 1'b1;
            drop_cnt_d  = sat_inc16(drop_cnt_q);
          end
        end
        if (!enable) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Pad the open packet with zeros before declaring the stream idle.
        if (pos_q != 14'd0) begin
          if (!fifo_full) begin
            fifo_wr    = 1'b1;
            fifo_wdata = {pos_last, 32'd0};
            pos_d      = pos_next;
          end
        end else if (fifo_empty && !out_vld_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (hs && out_last_q) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
    if (cnt_clr) begin
      drop_flag_d = 1'b0;
      drop_cnt_d  = '0;
      pkt_cnt_d   = '0;
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    if (fifo_rd) begin
      out_vld_d  = 1'b1;
      out_data_d = fifo_rdata[31:0];
      out_last_d = fifo_rdata[32];
    end else if (hs) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= DEF_PKT_LEN;
      pos_q       <= '0;
      drop_flag_q <= 1'b0;
      drop_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pos_q       <= pos_d;
      drop_flag_q <= drop_flag_d;
      drop_cnt_q  <= drop_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign axis_tvalid = out_vld_q;
  assign axis_tdata  = out_data_q;
  assign axis_tlast  = out_last_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty || out_vld_q;
  assign drop_flag   = drop_flag_q;
  assign drop_cnt    = drop_cnt_q;
  assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_adc_axis_packer.sv
// Directed bench for adc_axis_packer: framing, padding, overflow, stalls,
// counter clear, default length and asynchronous reset.
module tb_adc_axis_packer;

  logic        axis_clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [13:0] pkt_len;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        axis_tvalid;
  logic [31:0] axis_tdata;
  logic        axis_tlast;
  logic        axis_tready;
  logic        cnt_clr;
  logic        busy;
  logic        drop_flag;
  logic [15:0] drop_cnt;
  logic [15:0] pkt_cnt;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [32:0] got[$];
  int          got_cyc[$];
  bit          prev_stall = 1'b0;
  logic [32:0] prev_word  = '0;

  adc_axis_packer #(.FIFO_AW(4)) dut (
    .axis_clk    (axis_clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pkt_len     (pkt_len),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .axis_tvalid (axis_tvalid),
    .axis_tdata  (axis_tdata),
    .axis_tlast  (axis_tlast),
    .axis_tready (axis_tready),
    .cnt_clr     (cnt_clr),
    .busy        (busy),
    .drop_flag   (drop_flag),
    .drop_cnt    (drop_cnt),
    .pkt_cnt     (pkt_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] gw(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  function automatic logic [63:0] ew(input bit l, input logic [31:0] d);
    return {31'd0, l, d};
  endfunction

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 64'(busy), 64'(0));
  endtask

  // Handshake monitor plus stall-stability check, sampled mid-cycle.
  always @(negedge axis_clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold_stable", {30'd0, axis_tvalid, axis_tlast, axis_tdata}, {30'd0, 1'b1, prev_word});
      if (axis_tvalid && axis_tready) begin
        got.push_back({axis_tlast, axis_tdata});
        got_cyc.push_back(cyc);
      end
      prev_stall = axis_tvalid && !axis_tready;
      prev_word  = {axis_tlast, axis_tdata};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e2 [8];
    int nlast;
    e2 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd0, 32'd0};

    rst_n = 1'b0; enable = 1'b0; pkt_len = '0; sample_valid = 1'b0;
    sample_data = '0; axis_tready = 1'b1; cnt_clr = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", 64'(axis_tvalid), 64'(0));
    chk("rst_tdata",  64'(axis_tdata),  64'(0));
    chk("rst_tlast",  64'(axis_tlast),  64'(0));
    chk("rst_busy",   64'(busy),        64'(0));
    chk("rst_dflag",  64'(drop_flag),   64'(0));
    chk("rst_dcnt",   64'(drop_cnt),    64'(0));
    chk("rst_pcnt",   64'(pkt_cnt),     64'(0));
    rst_n = 1'b1;
    tick();

    // Two full packets of length 4, back-to-back
    got.delete();
    pkt_len = 14'd4; enable = 1'b1;
    tick();
    sample_valid = 1'b1; sample_data = 32'd1;
    tick();
    chk("lat_k1_vld", 64'(axis_tvalid), 64'(0));
    sample_data = 32'd2;
    tick();
    chk("lat_k2_vld",  64'(axis_tvalid), 64'(1));
    chk("lat_k2_data", 64'(axis_tdata),  64'(1));
    for (int i = 3; i <= 8; i++) send(32'(i));
    repeat (6) tick();
    chk("t1_count", 64'(got.size()), 64'(8));
    for (int i = 0; i < 8; i++) chk("t1_word", 64'(gw(i)), ew(i % 4 == 3, 32'(i + 1)));
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'(2));
    enable = 1'b0;
    wait_idle("t1_idle", 10);

    // Partial packet padded on stop; strobe while idle is ignored
    got.delete();
    send(32'hDEAD);
    chk("t2_idle_nodrop", 64'(drop_cnt), 64'(0));
    enable = 1'b1;
    tick();
    for (int i = 1; i <= 6; i++) send(32'(i));
    enable = 1'b0;
    wait_idle("t2_idle", 30);
    chk("t2_count", 64'(got.size()), 64'(8));
    for (int i = 0; i < 8; i++) chk("t2_word", 64'(gw(i)), ew(i % 4 == 3, e2[i]));
    chk("t2_pkt_cnt", 64'(pkt_cnt), 64'(4));

    // Overflow with sink stalled, then gapless release
    got.delete(); got_cyc.delete();
    axis_tready = 1'b0; enable = 1'b1;
    tick();
    for (int i = 1; i <= 20; i++) send(32'h100 + 32'(i));
    chk("t3_drop_cnt",  64'(drop_cnt),    64'(3));
    chk("t3_drop_flag", 64'(drop_flag),   64'(1));
    chk("t3_vld",       64'(axis_tvalid), 64'(1));
    chk("t3_head",      64'(axis_tdata),  64'(32'h101));
    axis_tready = 1'b1;
    repeat (20) tick();
    chk("t3_count", 64'(got.size()), 64'(17));
    for (int i = 0; i < 17; i++) chk("t3_word", 64'(gw(i)), ew(i % 4 == 3, 32'h101 + 32'(i)));
    if (got_cyc.size() >= 17) chk("t3_gapless", 64'(got_cyc[16] - got_cyc[0]), 64'(16));
    else chk("t3_gapless_n", 64'(got_cyc.size()), 64'(17));
    chk("t3_pkt_cnt", 64'(pkt_cnt), 64'(8));
    enable = 1'b0;
    wait_idle("t3_idle", 20);
    chk("t3_pad_count", 64'(got.size()), 64'(20));
    for (int i = 17; i < 20; i++) chk("t3_pad", 64'(gw(i)), ew(i == 19, 32'd0));
    chk("t3_pkt_cnt2", 64'(pkt_cnt), 64'(9));
    chk("t3_drop_keep", 64'(drop_cnt), 64'(3));

    // Alternating tready during one packet
    got.delete();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      axis_tready  = (i % 2 == 0);
      sample_valid = (i < 4);
      sample_data  = (i < 4) ? 32'h201 + 32'(i) : 32'd0;
      tick();
    end
    sample_valid = 1'b0; axis_tready = 1'b1;
    repeat (4) tick();
    chk("t4_count", 64'(got.size()), 64'(4));
    for (int i = 0; i < 4; i++) chk("t4_word", 64'(gw(i)), ew(i == 3, 32'h201 + 32'(i)));
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'(10));

    // Clear coinciding with a tlast handshake and a drop
    got.delete();
    for (int i = 1; i <= 3; i++) send(32'h300 + 32'(i));
    repeat (4) tick();
    axis_tready = 1'b0;
    for (int i = 1; i <= 17; i++) send(32'h310 + 32'(i));
    chk("t5_pre_vld",  64'(axis_tvalid), 64'(1));
    chk("t5_pre_last", 64'(axis_tlast),  64'(1));
    chk("t5_pre_data", 64'(axis_tdata),  64'(32'h311));
    chk("t5_pre_drop", 64'(drop_cnt),    64'(3));
    cnt_clr = 1'b1; axis_tready = 1'b1; sample_valid = 1'b1; sample_data = 32'hBAD;
    tick();
    cnt_clr = 1'b0; sample_valid = 1'b0;
    chk("t5_clr_pkt",   64'(pkt_cnt),   64'(0));
    chk("t5_clr_drop",  64'(drop_cnt),  64'(0));
    chk("t5_clr_dflag", 64'(drop_flag), 64'(0));
    enable = 1'b0;
    wait_idle("t5_idle", 40);
    chk("t5_count", 64'(got.size()), 64'(20));
    chk("t5_tail",  64'(gw(19)), ew(1'b1, 32'h321));
    chk("t5_pkt_cnt", 64'(pkt_cnt), 64'(4));

    // Default length of 256 words
    got.delete();
    pkt_len = 14'd0; enable = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) send(32'(i + 1));
    repeat (5) tick();
    chk("t6_count", 64'(got.size()), 64'(256));
    nlast = 0;
    foreach (got[i]) if (got[i][32]) nlast++;
    chk("t6_nlast", 64'(nlast), 64'(1));
    chk("t6_last_word", 64'(gw(255)), ew(1'b1, 32'd256));
    chk("t6_pkt_cnt", 64'(pkt_cnt), 64'(5));

    // Asynchronous reset mid-packet, then a fresh capture
    for (int i = 0; i < 10; i++) send(32'h500 + 32'(i));
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_tvalid", 64'(axis_tvalid), 64'(0));
    chk("ar_tdata",  64'(axis_tdata),  64'(0));
    chk("ar_busy",   64'(busy),        64'(0));
    chk("ar_pcnt",   64'(pkt_cnt),     64'(0));
    tick();
    got.delete();
    pkt_len = 14'd4;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(32'h401 + 32'(i));
    repeat (5) tick();
    chk("ar_count", 64'(got.size()), 64'(4));
    for (int i = 0; i < 4; i++) chk("ar_word", 64'(gw(i)), ew(i == 3, 32'h401 + 32'(i)));
    chk("ar_pkt_cnt", 64'(pkt_cnt), 64'(1));
    enable = 1'b0;
    wait_idle("ar_idle", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
